// File: rtl/mbs_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbs_bus_pkg
// Description : Shared constants for the RAM bus arbiter (states, ctrl bits,
//               master indices).
// Revision    : 1.0 - initial release
// ============================================================================
package mbs_bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam int RAM_RE_BIT = 0;
    localparam int RAM_WE_BIT = 1;

    localparam int M_CPU_DATA = 0;
    localparam int M_CPU_INST = 1;
    localparam int M_DMA      = 2;

endpackage
`default_nettype wire

// File: rtl/mbs_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mbs_rr_pick
// Description : Combinational round-robin picker; first request after last_i.
// Revision    : 1.0 - initial release
// ============================================================================
module mbs_rr_pick #(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [2:0]             last_i,
    output logic                   valid_o,
    output logic [2:0]             idx_o
);

    always_comb begin : p_pick
        int d;
        int best;
        valid_o = 1'b0;
        idx_o   = '0;
        best    = NUM_MASTERS;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            // Distance from the slot just after the last grant, modulo NUM_MASTERS.
            d = k - int'(last_i) - 1;
            if (d < 0) begin
                d = d + NUM_MASTERS;
            end
            if (req_i[k] && (d < best)) begin
                best    = d;
                valid_o = 1'b1;
                idx_o   = 3'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mbs_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mbs_bus_arbiter
// Description : Round-robin arbiter sharing the SoC RAM bus among masters,
//               with fixed wait states and a one-cycle ack per transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module mbs_bus_arbiter
    import mbs_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS-1:0]            we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              busy,
    output logic [2:0]                        grant_id,
    output logic [ADDR_WIDTH-1:0]             addr_bus,
    output logic [DATA_WIDTH-1:0]             wdata_bus,
    input  logic [DATA_WIDTH-1:0]             rdata_bus,
    output logic                              ram_re,
    output logic                              ram_we
);

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [2:0]             grant_q, grant_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [1:0]             ctrl_q, ctrl_d;

    logic [NUM_MASTERS-1:0] w_grant_mask;
    logic [NUM_MASTERS-1:0] w_req_eff;
    logic                   w_valid;
    logic [2:0]             w_win;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic                   w_sel_we;
    logic                   w_start;

    // The master being acked is excluded from the overlapped re-arbitration.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_grant_mask[i] = (grant_q == 3'(i));
        end
        w_req_eff = (state_q == ST_ACK) ? (req & ~w_grant_mask) : req;
    end

    mbs_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req_i   (w_req_eff),
        .last_i  (ptr_q),
        .valid_o (w_valid),
        .idx_o   (w_win)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_win == 3'(i)) begin
                w_sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_we    = we[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        w_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_start = w_valid;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'(WAIT_CYCLES)) begin
                    state_d = ST_ACK;
                    if (ctrl_q[RAM_RE_BIT]) begin
                        rdata_d = rdata_bus;
                    end
                    ack_d   = w_grant_mask;
                    addr_d  = '0;
                    wdata_d = '0;
                    ctrl_d  = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACK: begin
                w_start = w_valid;
                if (!w_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_start) begin
            state_d            = ST_ACCESS;
            cnt_d              = '0;
            ptr_d              = w_win;
            grant_d            = w_win;
            addr_d             = w_sel_addr;
            wdata_d            = w_sel_wdata;
            ctrl_d[RAM_RE_BIT] = ~w_sel_we;
            ctrl_d[RAM_WE_BIT] = w_sel_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 3'(NUM_MASTERS - 1);
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign addr_bus  = addr_q;
    assign wdata_bus = wdata_q;
    assign ram_re    = ctrl_q[RAM_RE_BIT];
    assign ram_we    = ctrl_q[RAM_WE_BIT];

endmodule
`default_nettype wire
